// File: rtl/mem_rmw_arb.sv
// mem_rmw_arb: arbiter and sequencer for the single-port synchronous core RAM.
// It is shared by instruction fetch (IF) and the load/store path (LS).
//   - Loads, fetches and SW use one RAM cycle.
//   - SB/SH use a read-modify-write: read the word, then write it back with
//     the new byte lanes merged in.
//   - Load data is returned as the raw word; lane extraction happens at
//     writeback.
//
// Ports:
//   clk, arst_n              core clock, asynchronous active-low reset
//   if_req_i/if_addr_i       fetch request and word-aligned byte address
//   if_gnt_o                 fetch owns the RAM this cycle
//   if_valid_o/if_rdata_o    fetch word, one cycle after the grant
//   ls_req_i/ls_we_i/ls_funct3_i/ls_addr_i/ls_wdata_i
//                            LS request, held by the requester until ls_valid_o
//   ls_gnt_o                 LS owns the RAM this cycle
//   ls_valid_o/ls_rdata_o    LS done; raw load word
//   ls_err_o                 misaligned-access error (trap build only)
//   stall_o                  LS request outstanding
//   ram_ce_o/ram_we_o/ram_addr_o/ram_wdata_o/ram_rdata_i
//                            RAM port; read data arrives the cycle after a read
//
// Build option: define MEM_RMW_ARB_MISALIGN_TRAP_EN to trap misaligned
// LH/LHU/SH/LW/SW. Such an access is granted, makes no RAM access, and
// completes one cycle later with ls_err_o=1. Without the macro, the low
// address bits are ignored for alignment.
module mem_rmw_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_valid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [2:0]        ls_funct3_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    output logic              ls_gnt_o,
    output logic              ls_valid_o,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic              ls_err_o,
    output logic              stall_o,
    output logic              ram_ce_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, RMW_WR, ST_ACK} state_t;

    state_t            state_q, state_d;
    logic              fair_q, fair_d;     // IF wins the next tie
    logic              rd_if_q, rd_if_d;   // owner of the read in RD_WAIT
    logic              half_q, half_d;     // captured RMW size: 1 = SH, 0 = SB
    logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
    logic [15:0]       cap_wdata_q, cap_wdata_d;
    logic              misalign, is_sub;
    logic              if_gnt, ls_gnt, if_valid, ls_valid, ram_ce, ram_we;
    logic [DATA_W-1:0] if_rdata, ls_rdata, ram_wdata, merged;
    logic [ADDR_W-1:0] ram_addr;
`ifdef MEM_RMW_ARB_MISALIGN_TRAP_EN
    logic              err_q, err_d, ls_err;
`endif

    // Fetch addresses are word-aligned by contract; the low bits carry nothing.
    logic unused_if_lsb;
    assign unused_if_lsb = ^if_addr_i[1:0];

    // SB (000) and SH (001) need the read-modify-write.
    // Every other store funct3 is handled as SW.
    assign is_sub = ls_we_i & ((ls_funct3_i == 3'b000) | (ls_funct3_i == 3'b001));

`ifdef MEM_RMW_ARB_MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        case (ls_funct3_i)
            3'b001:  misalign = ls_addr_i[0];                // LH / SH
            3'b101:  misalign = ~ls_we_i & ls_addr_i[0];     // LHU (loads only)
            3'b010:  misalign = |ls_addr_i[1:0];             // LW / SW
            default: misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    // Merge the captured store lanes into the word read in the previous cycle.
    always_comb begin
        merged = ram_rdata_i;
        if (half_q) begin
            if (cap_addr_q[1]) merged[31:16] = cap_wdata_q;
            else               merged[15:0]  = cap_wdata_q;
        end else begin
            case (cap_addr_q[1:0])
                2'd0:    merged[7:0]   = cap_wdata_q[7:0];
                2'd1:    merged[15:8]  = cap_wdata_q[7:0];
                2'd2:    merged[23:16] = cap_wdata_q[7:0];
                default: merged[31:24] = cap_wdata_q[7:0];
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        fair_d      = fair_q;
        rd_if_d     = rd_if_q;
        half_d      = half_q;
        cap_addr_d  = cap_addr_q;
        cap_wdata_d = cap_wdata_q;
`ifdef MEM_RMW_ARB_MISALIGN_TRAP_EN
        err_d       = err_q;
        ls_err      = 1'b0;
`endif
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        if_valid  = 1'b0;
        ls_valid  = 1'b0;
        if_rdata  = '0;
        ls_rdata  = '0;
        ram_ce    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state_q)
            IDLE: begin
                // LS wins ties unless IF was passed over at the last LS completion.
                if (ls_req_i && !(if_req_i && fair_q)) begin
                    ls_gnt = 1'b1;
                    if (misalign) begin
`ifdef MEM_RMW_ARB_MISALIGN_TRAP_EN
                        err_d = 1'b1;
`endif
                        state_d = ST_ACK;
                    end else if (is_sub) begin
                        ram_ce      = 1'b1;
                        ram_addr    = {ls_addr_i[ADDR_W-1:2], 2'b00};
                        cap_addr_d  = ls_addr_i;
                        cap_wdata_d = ls_wdata_i[15:0];
                        half_d      = ls_funct3_i[0];
                        state_d     = RMW_WR;
                    end else if (ls_we_i) begin
                        ram_ce    = 1'b1;
                        ram_we    = 1'b1;
                        ram_addr  = {ls_addr_i[ADDR_W-1:2], 2'b00};
                        ram_wdata = ls_wdata_i;
                        state_d   = ST_ACK;
                    end else begin
                        ram_ce   = 1'b1;
                        ram_addr = {ls_addr_i[ADDR_W-1:2], 2'b00};
                        rd_if_d  = 1'b0;
                        state_d  = RD_WAIT;
                    end
                end else if (if_req_i) begin
                    if_gnt   = 1'b1;
                    ram_ce   = 1'b1;
                    ram_addr = {if_addr_i[ADDR_W-1:2], 2'b00};
                    rd_if_d  = 1'b1;
                    fair_d   = 1'b0;
                    state_d  = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rd_if_q) begin
                    if_valid = 1'b1;
                    if_rdata = ram_rdata_i;
                end else begin
                    ls_valid = 1'b1;
                    ls_rdata = ram_rdata_i;
                    fair_d   = fair_q | if_req_i;
                end
                state_d = IDLE;
            end
            RMW_WR: begin
                ram_ce    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = {cap_addr_q[ADDR_W-1:2], 2'b00};
                ram_wdata = merged;
                state_d   = ST_ACK;
            end
            ST_ACK: begin
                ls_valid = 1'b1;
`ifdef MEM_RMW_ARB_MISALIGN_TRAP_EN
                ls_err   = err_q;
                err_d    = 1'b0;
`endif
                fair_d   = fair_q | if_req_i;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= IDLE;
            fair_q      <= 1'b0;
            rd_if_q     <= 1'b0;
            half_q      <= 1'b0;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
`ifdef MEM_RMW_ARB_MISALIGN_TRAP_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            fair_q      <= fair_d;
            rd_if_q     <= rd_if_d;
            half_q      <= half_d;
            cap_addr_q  <= cap_addr_d;
            cap_wdata_q <= cap_wdata_d;
`ifdef MEM_RMW_ARB_MISALIGN_TRAP_EN
            err_q       <= err_d;
`endif
        end
    end

    // Outputs are forced low while reset is held, so a pending RMW write
    // cannot reach the RAM.
    assign if_gnt_o    = arst_n & if_gnt;
    assign ls_gnt_o    = arst_n & ls_gnt;
    assign if_valid_o  = arst_n & if_valid;
    assign ls_valid_o  = arst_n & ls_valid;
    assign if_rdata_o  = arst_n ? if_rdata : '0;
    assign ls_rdata_o  = arst_n ? ls_rdata : '0;
    assign stall_o     = arst_n & ls_req_i & ~ls_valid;
    assign ram_ce_o    = arst_n & ram_ce;
    assign ram_we_o    = arst_n & ram_we;
    assign ram_addr_o  = arst_n ? ram_addr : '0;
    assign ram_wdata_o = arst_n ? ram_wdata : '0;
`ifdef MEM_RMW_ARB_MISALIGN_TRAP_EN
    assign ls_err_o    = arst_n & ls_err;
`else
    assign ls_err_o    = 1'b0;
`endif
endmodule

// File: tb/tb_mem_rmw_arb.sv
module tb_mem_rmw_arb;
    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    always #5 clk = ~clk;

    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = 32'h100;
    logic        if_gnt_o, if_valid_o;
    logic [31:0] if_rdata_o;
    logic        ls_req_i = 1'b0, ls_we_i = 1'b0;
    logic [2:0]  ls_funct3_i = 3'b010;
    logic [31:0] ls_addr_i = 32'h100, ls_wdata_i = 32'h0;
    logic        ls_gnt_o, ls_valid_o, ls_err_o, stall_o;
    logic [31:0] ls_rdata_o;
    logic        ram_ce_o, ram_we_o;
    logic [31:0] ram_addr_o, ram_wdata_o, ram_rdata_i;

    mem_rmw_arb #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .arst_n(arst_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_valid_o(if_valid_o), .if_rdata_o(if_rdata_o),
        .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_funct3_i(ls_funct3_i),
        .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o),
        .ls_valid_o(ls_valid_o), .ls_rdata_o(ls_rdata_o), .ls_err_o(ls_err_o),
        .stall_o(stall_o), .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o),
        .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
    );

    // Environment RAM: 64 words covering byte addresses 0x100..0x1FF.
    logic [31:0] ram [0:63] = '{default: 32'h0};
    logic [31:0] ram_rd_q = 32'h0;
    always @(posedge clk) begin
        if (ram_ce_o) begin
            if (ram_we_o) ram[ram_addr_o[7:2]] <= ram_wdata_o;
            else          ram_rd_q <= ram[ram_addr_o[7:2]];
        end
    end
    assign ram_rdata_i = ram_rd_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a word array updated in grant order, with byte-lane
    // stores computed from access size and address.
    typedef struct { int cyc; logic [31:0] data; logic err; logic chk_data; } exp_t;
    typedef struct { int cyc; logic [31:0] addr; logic [31:0] data; } wr_t;
    logic [31:0] ref_mem [0:63] = '{default: 32'h0};
    exp_t q_if[$], q_ls[$];
    wr_t  q_wr[$];
    bit   glog[$];
    bit   mon_en = 0, log_en = 0, if_en = 0, if_force = 0;

    function automatic void ls_model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] wd, output exp_t e, output bit wr, output wr_t w);
        int size, start;
        logic [31:0] word;
        bit mis;
        size = !we ? 4 : (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        mis = 0;
`ifdef MEM_RMW_ARB_MISALIGN_TRAP_EN
        if (f3 == 3'd1 || (!we && f3 == 3'd5)) mis = a[0];
        if (f3 == 3'd2) mis = (a[1:0] != 2'd0);
`endif
        e.cyc = cyc + ((we && size < 4 && !mis) ? 2 : 1);
        e.err = mis;
        wr = 0;
        w.cyc = 0; w.addr = 0; w.data = 0;
        if (mis) begin
            e.data = 0; e.chk_data = 1;
        end else if (!we) begin
            e.data = ref_mem[a[7:2]]; e.chk_data = 1;
        end else begin
            word  = ref_mem[a[7:2]];
            start = (size == 1) ? int'(a[1:0]) : (size == 2) ? (a[1] ? 2 : 0) : 0;
            for (int k = 0; k < size; k++) word[8*(start+k) +: 8] = wd[8*k +: 8];
            ref_mem[a[7:2]] = word;
            e.data = 0; e.chk_data = 0;
            wr = 1;
            w.cyc = cyc + ((size < 4) ? 1 : 0);
            w.addr = {a[31:2], 2'b00};
            w.data = word;
        end
    endfunction

    // Monitor: push expectations on grants, pop and compare on valids/writes.
    always @(negedge clk) begin
        exp_t e;
        wr_t  w;
        bit   wr;
        if (mon_en) begin
            chk("gnt_excl", {31'b0, if_gnt_o & ls_gnt_o}, 32'h0);
            chk("stall", {31'b0, stall_o}, {31'b0, ls_req_i & ~ls_valid_o});
            if (if_gnt_o) begin
                e.cyc = cyc + 1; e.data = ref_mem[if_addr_i[7:2]]; e.err = 0; e.chk_data = 1;
                q_if.push_back(e);
                chk("if_ram_addr", ram_addr_o, {if_addr_i[31:2], 2'b00});
                if (log_en) glog.push_back(0);
            end
            if (ls_gnt_o) begin
                ls_model(ls_we_i, ls_funct3_i, ls_addr_i, ls_wdata_i, e, wr, w);
                q_ls.push_back(e);
                if (wr) q_wr.push_back(w);
                if (e.err) chk("err_no_ce", {31'b0, ram_ce_o}, 32'h0);
                if (log_en) glog.push_back(1);
            end
            if (ram_ce_o && ram_we_o) begin
                if (q_wr.size() == 0) chk("unexpected_write", 32'h1, 32'h0);
                else begin
                    w = q_wr.pop_front();
                    chk("wr_cycle", cyc, w.cyc);
                    chk("wr_addr", ram_addr_o, w.addr);
                    chk("wr_data", ram_wdata_o, w.data);
                end
            end
            if (if_valid_o) begin
                if (q_if.size() == 0) chk("unexpected_if_valid", 32'h1, 32'h0);
                else begin
                    e = q_if.pop_front();
                    chk("if_lat", cyc, e.cyc);
                    chk("if_rdata", if_rdata_o, e.data);
                end
            end
            if (ls_valid_o) begin
                if (q_ls.size() == 0) chk("unexpected_ls_valid", 32'h1, 32'h0);
                else begin
                    e = q_ls.pop_front();
                    chk("ls_lat", cyc, e.cyc);
                    chk("ls_err", {31'b0, ls_err_o}, {31'b0, e.err});
                    if (e.chk_data) chk("ls_rdata", ls_rdata_o, e.data);
                end
            end
        end
    end

    // Fetch driver.
    initial forever begin
        @(posedge clk); #1;
        if_req_i  = if_en && (if_force || $urandom_range(0, 3) == 0);
        if_addr_i = 32'h100 + (32'($urandom_range(0, 63)) << 2);
    end

    task automatic ls_op(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        bit done;
        done = 0;
        ls_req_i = 1; ls_we_i = we; ls_funct3_i = f3; ls_addr_i = a; ls_wdata_i = wd;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            if (ls_valid_o) done = 1;
        end
        if (!done) chk("ls_timeout", 32'h0, 32'h1);
        @(posedge clk); #1;
        ls_req_i = 0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ctrl0", {24'b0, if_gnt_o, if_valid_o, ls_gnt_o, ls_valid_o, ls_err_o, stall_o, ram_ce_o, ram_we_o}, 32'h0);
        chk("rst_bus0", if_rdata_o | ls_rdata_o | ram_addr_o | ram_wdata_o, 32'h0);
        arst_n = 1;
        @(posedge clk); #1;
        mon_en = 1;
        ls_op(1, 3'b010, 32'h100, 32'h11223344);

        // Reset in the middle of an SB read-modify-write.
        idle_cycles(3);
        mon_en = 0;
        ls_req_i = 1; ls_we_i = 1; ls_funct3_i = 3'b000; ls_addr_i = 32'h103; ls_wdata_i = 32'hAA;
        @(negedge clk);
        chk("rst_sb_gnt", {31'b0, ls_gnt_o}, 32'h1);
        @(posedge clk); #1;
        arst_n = 0; ls_req_i = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_we", {31'b0, ram_we_o}, 32'h0);
            chk("rst_ctrl", {24'b0, if_gnt_o, if_valid_o, ls_gnt_o, ls_valid_o, ls_err_o, stall_o, ram_ce_o, ram_we_o}, 32'h0);
            chk("rst_bus", if_rdata_o | ls_rdata_o | ram_addr_o | ram_wdata_o, 32'h0);
        end
        chk("rst_no_write", ram[0], 32'h11223344);
        arst_n = 1;
        @(posedge clk); #1;
        mon_en = 1; if_en = 1;

        ls_op(0, 3'b010, 32'h100, 32'h0);
        ls_op(1, 3'b000, 32'h103, 32'h000000AA);
        chk("sb_word", ram[0], 32'hAA223344);
        ls_op(1, 3'b001, 32'h102, 32'h0000BEEF);
        chk("sh_word", ram[0], 32'hBEEF3344);
        ls_op(1, 3'b010, 32'h101, 32'h55667788);
`ifdef MEM_RMW_ARB_MISALIGN_TRAP_EN
        chk("sw_misalign", ram[0], 32'hBEEF3344);
`else
        chk("sw_misalign", ram[0], 32'h55667788);
`endif
        ls_op(0, 3'b000, 32'h100, 32'h0);

        // Randomized mix of all funct3 codes, addresses and gaps.
        for (int i = 0; i < 120; i++) begin
            ls_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  32'h100 + 32'($urandom_range(0, 255)), $urandom);
            idle_cycles($urandom_range(0, 2));
        end

        // Both requesters held high: grants must alternate.
        if_force = 1;
        idle_cycles(3);
        glog.delete();
        log_en = 1;
        for (int i = 0; i < 10; i++)
            ls_op(1'(i % 2), (i % 3 == 0) ? 3'b000 : 3'b010,
                  32'h100 + (32'($urandom_range(0, 63)) << 2), $urandom);
        log_en = 0;
        if_force = 0;
        chk("alt_count", {31'b0, glog.size() >= 19}, 32'h1);
        for (int i = 1; i < glog.size(); i++)
            chk($sformatf("alternate[%0d]", i), {31'b0, glog[i]}, {31'b0, ~glog[i-1]});

        if_en = 0;
        idle_cycles(6);
        chk("q_if_empty", q_if.size(), 32'h0);
        chk("q_ls_empty", q_ls.size(), 32'h0);
        chk("q_wr_empty", q_wr.size(), 32'h0);
        for (int k = 0; k < 64; k++) chk($sformatf("mem[%0d]", k), ram[k], ref_mem[k]);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
